// File: rtl/lock_relock_ctrl.sv
// Lock supervisor and relock sequencer placed downstream of the PID block.
// While locked, the PID output passes through. After a sustained loss of lock,
// the block resets and freezes the PID and sweeps the actuator with a triangle
// ramp until the monitor is back in its window. It then hands control back to
// the PID.
// Optional feature: define LOCK_RELOCK_TIMEOUT_EN to count sweep periods and
// enter FAIL after max_sweeps_i of them.
module lock_relock_ctrl (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               enable_i,
   input  logic signed [13:0] pid_dat_i,
   input  logic signed [13:0] sig_i,
   input  logic signed [13:0] win_min_i,
   input  logic signed [13:0] win_max_i,
   input  logic [15:0]        hold_cnt_i,
   input  logic [15:0]        settle_cnt_i,
   input  logic signed [13:0] ramp_min_i,
   input  logic signed [13:0] ramp_max_i,
   input  logic [13:0]        ramp_step_i,
   input  logic [15:0]        ramp_div_i,
   input  logic [7:0]         max_sweeps_i,
   output logic signed [13:0] dat_o,
   output logic               int_rst_o,
   output logic               pid_freeze_o,
   output logic               locked_o,
   output logic [2:0]         state_o
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLocked = 3'd1,
      StVerify = 3'd2,
      StSweep  = 3'd3,
      StSettle = 3'd4,
      StFail   = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic               in_win_q;
   logic [15:0]        out_cnt_q, out_cnt_d;
   logic [15:0]        in_cnt_q, in_cnt_d;
   logic [15:0]        div_cnt_q, div_cnt_d;
   logic signed [13:0] ramp_q, ramp_d;
   logic               up_q, up_d;
   logic signed [13:0] dat_q, dat_d;
   logic               int_rst_q, int_rst_d;
   logic               locked_q, locked_d;

   logic [15:0]        hold_eff, settle_eff;
   logic               ramp_tick;
   logic signed [13:0] ramp_nxt;
   logic               up_nxt;
   logic               ramp_wrap;
   logic signed [13:0] entry_val;
   logic signed [14:0] r_ext, step_ext, min_ext, max_ext, sum;

`ifdef LOCK_RELOCK_TIMEOUT_EN
   logic [7:0]         sweep_cnt_q, sweep_cnt_d;
`else
   logic               unused_timeout;
   assign unused_timeout = ^{max_sweeps_i, ramp_wrap};
`endif

   // A zero count behaves like one.
   assign hold_eff   = (hold_cnt_i == 16'd0) ? 16'd1 : hold_cnt_i;
   assign settle_eff = (settle_cnt_i == 16'd0) ? 16'd1 : settle_cnt_i;
   assign ramp_tick  = (div_cnt_q >= ramp_div_i);

   // Candidate ramp value for the next tick, with limit folding and reversal.
   always_comb begin
      ramp_nxt  = ramp_q;
      up_nxt    = up_q;
      ramp_wrap = 1'b0;
      r_ext     = {ramp_q[13], ramp_q};
      step_ext  = {1'b0, ramp_step_i};
      min_ext   = {ramp_min_i[13], ramp_min_i};
      max_ext   = {ramp_max_i[13], ramp_max_i};
      sum       = up_q ? (r_ext + step_ext) : (r_ext - step_ext);
      if (ramp_min_i > ramp_max_i) begin
         // Inverted limits pin the ramp; no reversals are counted.
         ramp_nxt = ramp_min_i;
      end else if (sum > max_ext) begin
         ramp_nxt = ramp_max_i;
         if (up_q) up_nxt = 1'b0;
      end else if (sum < min_ext) begin
         ramp_nxt = ramp_min_i;
         if (!up_q) begin
            up_nxt    = 1'b1;
            ramp_wrap = 1'b1;
         end
      end else begin
         ramp_nxt = sum[13:0];
      end
   end

   // Starting point for a fresh sweep: current output clamped into the ramp limits.
   always_comb begin
      if (ramp_min_i > ramp_max_i)  entry_val = ramp_min_i;
      else if (dat_q < ramp_min_i)  entry_val = ramp_min_i;
      else if (dat_q > ramp_max_i)  entry_val = ramp_max_i;
      else                          entry_val = dat_q;
   end

   // State register and registered window flag.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= StIdle;
         in_win_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_win_q <= (sig_i >= win_min_i) && (sig_i <= win_max_i);
      end
   end

   // Next state and hold/settle/sweep counters.
   always_comb begin
      state_d   = state_q;
      out_cnt_d = out_cnt_q;
      in_cnt_d  = in_cnt_q;
`ifdef LOCK_RELOCK_TIMEOUT_EN
      sweep_cnt_d = sweep_cnt_q;
`endif
      if (!enable_i) begin
         state_d   = StIdle;
         out_cnt_d = 16'd0;
         in_cnt_d  = 16'd0;
`ifdef LOCK_RELOCK_TIMEOUT_EN
         sweep_cnt_d = 8'd0;
`endif
      end else begin
         unique case (state_q)
            StIdle: state_d = in_win_q ? StLocked : StSweep;
            StLocked: begin
               if (!in_win_q) begin
                  if (hold_eff == 16'd1) begin
                     state_d = StSweep;
                  end else begin
                     state_d   = StVerify;
                     out_cnt_d = 16'd1;
                  end
               end
            end
            StVerify: begin
               if (in_win_q) begin
                  state_d   = StLocked;
                  out_cnt_d = 16'd0;
               end else begin
                  out_cnt_d = out_cnt_q + 16'd1;
                  if (out_cnt_d >= hold_eff) begin
                     state_d   = StSweep;
                     out_cnt_d = 16'd0;
                  end
               end
            end
            StSweep: begin
`ifdef LOCK_RELOCK_TIMEOUT_EN
               if (ramp_tick && ramp_wrap) sweep_cnt_d = sweep_cnt_q + 8'd1;
               if ((max_sweeps_i != 8'd0) && (sweep_cnt_d == max_sweeps_i)) begin
                  state_d = StFail;
               end else if (in_win_q) begin
                  state_d  = StSettle;
                  in_cnt_d = 16'd1;
               end
`else
               if (in_win_q) begin
                  state_d  = StSettle;
                  in_cnt_d = 16'd1;
               end
`endif
            end
            StSettle: begin
               if (!in_win_q) begin
                  state_d  = StSweep;
                  in_cnt_d = 16'd0;
               end else begin
                  in_cnt_d = in_cnt_q + 16'd1;
                  if (in_cnt_d >= settle_eff) begin
                     state_d  = StLocked;
                     in_cnt_d = 16'd0;
`ifdef LOCK_RELOCK_TIMEOUT_EN
                     sweep_cnt_d = 8'd0;
`endif
                  end
               end
            end
            StFail:  state_d = StFail;
            default: state_d = StIdle;
         endcase
      end
   end

   // Ramp datapath: initialise on fresh sweep entry, advance on ticks while sweeping.
   always_comb begin
      ramp_d    = ramp_q;
      up_d      = up_q;
      div_cnt_d = div_cnt_q;
      if (!enable_i) begin
         div_cnt_d = 16'd0;
      end else if ((state_d == StSweep) &&
                   (state_q == StIdle || state_q == StLocked || state_q == StVerify)) begin
         ramp_d    = entry_val;
         up_d      = 1'b1;
         div_cnt_d = 16'd0;
      end else if (state_q == StSweep) begin
         if (ramp_tick) begin
            ramp_d    = ramp_nxt;
            up_d      = up_nxt;
            div_cnt_d = 16'd0;
         end else begin
            div_cnt_d = div_cnt_q + 16'd1;
         end
      end
   end

   // Registered outputs follow the state being entered.
   always_comb begin
      dat_d     = pid_dat_i;
      int_rst_d = 1'b0;
      locked_d  = 1'b0;
      unique case (state_d)
         StIdle:   dat_d = pid_dat_i;
         StLocked, StVerify: begin
            dat_d    = pid_dat_i;
            locked_d = 1'b1;
         end
         StSweep, StSettle: begin
            dat_d     = ramp_d;
            int_rst_d = 1'b1;
         end
         StFail: begin
            dat_d     = ramp_min_i;
            int_rst_d = 1'b1;
         end
         default: dat_d = pid_dat_i;
      endcase
   end

   // Counters, ramp and output registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         out_cnt_q <= 16'd0;
         in_cnt_q  <= 16'd0;
         div_cnt_q <= 16'd0;
         ramp_q    <= 14'sd0;
         up_q      <= 1'b1;
         dat_q     <= 14'sd0;
         int_rst_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         out_cnt_q <= out_cnt_d;
         in_cnt_q  <= in_cnt_d;
         div_cnt_q <= div_cnt_d;
         ramp_q    <= ramp_d;
         up_q      <= up_d;
         dat_q     <= dat_d;
         int_rst_q <= int_rst_d;
         locked_q  <= locked_d;
      end
   end

`ifdef LOCK_RELOCK_TIMEOUT_EN
   // Sweep period counter.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) sweep_cnt_q <= 8'd0;
      else         sweep_cnt_q <= sweep_cnt_d;
   end
`endif

   assign dat_o        = dat_q;
   assign int_rst_o    = int_rst_q;
   assign pid_freeze_o = int_rst_q;
   assign locked_o     = locked_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_lock_relock_ctrl.sv
// Bench for lock_relock_ctrl: a behavioural model checked every cycle plus
// directed scenarios with hand-computed values.
module tb_lock_relock_ctrl;

`ifdef LOCK_RELOCK_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic               clk  = 1'b0;
   logic               rstn = 1'b1;
   logic               enable = 1'b0;
   logic signed [13:0] pid = 14'sd1234;
   logic signed [13:0] sig = 14'sd100;
   logic signed [13:0] wmin = 14'sd0;
   logic signed [13:0] wmax = 14'sd200;
   logic [15:0]        hold = 16'd4;
   logic [15:0]        settle = 16'd5;
   logic signed [13:0] rmin = -14'sd100;
   logic signed [13:0] rmax = 14'sd100;
   logic [13:0]        rstep = 14'd30;
   logic [15:0]        rdiv = 16'd0;
   logic [7:0]         maxsw = 8'd0;
   logic signed [13:0] dat;
   logic               irst, frz, lck;
   logic [2:0]         st;

   int total = 0;
   int bad   = 0;
   bit run   = 1'b0;

   // Model state (plain integers).
   int m_state = 0, m_dat = 0, m_irst = 0, m_lock = 0, m_inwin = 0;
   int m_out = 0, m_in = 0, m_ramp = 0, m_up = 1, m_div = 0, m_sw = 0;

   lock_relock_ctrl dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .enable_i     (enable),
      .pid_dat_i    (pid),
      .sig_i        (sig),
      .win_min_i    (wmin),
      .win_max_i    (wmax),
      .hold_cnt_i   (hold),
      .settle_cnt_i (settle),
      .ramp_min_i   (rmin),
      .ramp_max_i   (rmax),
      .ramp_step_i  (rstep),
      .ramp_div_i   (rdiv),
      .max_sweeps_i (maxsw),
      .dat_o        (dat),
      .int_rst_o    (irst),
      .pid_freeze_o (frz),
      .locked_o     (lck),
      .state_o      (st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model of the supervisor rules.
   always @(posedge clk or negedge rstn) begin
      int he, se, ns, no, ni, nr, nu, ndv, nsw, nd, cand, lo, hi;
      bit win;
      if (!rstn) begin
         m_state <= 0; m_dat <= 0; m_irst <= 0; m_lock <= 0; m_inwin <= 0;
         m_out <= 0; m_in <= 0; m_ramp <= 0; m_up <= 1; m_div <= 0; m_sw <= 0;
      end else begin
         he  = (hold == 0) ? 1 : int'(hold);
         se  = (settle == 0) ? 1 : int'(settle);
         lo  = int'(rmin);
         hi  = int'(rmax);
         win = (m_inwin != 0);
         ns = m_state; no = m_out; ni = m_in; nr = m_ramp; nu = m_up; ndv = m_div; nsw = m_sw;
         if (!enable) begin
            ns = 0; no = 0; ni = 0; ndv = 0; nsw = 0;
         end else begin
            case (m_state)
               0: ns = win ? 1 : 3;
               1: if (!win) begin
                     if (he == 1) ns = 3;
                     else begin ns = 2; no = 1; end
                  end
               2: if (win) begin ns = 1; no = 0; end
                  else if (m_out + 1 >= he) begin ns = 3; no = 0; end
                  else no = m_out + 1;
               3: begin
                  if (m_div >= int'(rdiv)) begin
                     ndv  = 0;
                     cand = (m_up != 0) ? m_ramp + int'(rstep) : m_ramp - int'(rstep);
                     if (lo > hi) nr = lo;
                     else if (cand > hi) begin nr = hi; if (m_up != 0) nu = 0; end
                     else if (cand < lo) begin
                        nr = lo;
                        if (m_up == 0) begin nu = 1; nsw = m_sw + 1; end
                     end else nr = cand;
                  end else ndv = m_div + 1;
                  if (TimeoutEn && maxsw != 0 && nsw == int'(maxsw)) ns = 5;
                  else if (win) begin ns = 4; ni = 1; end
               end
               4: if (!win) begin ns = 3; ni = 0; end
                  else if (m_in + 1 >= se) begin ns = 1; ni = 0; nsw = 0; end
                  else ni = m_in + 1;
               default: ;
            endcase
            if (ns == 3 && m_state <= 2) begin
               if (lo > hi || m_dat < lo) nr = lo;
               else if (m_dat > hi) nr = hi;
               else nr = m_dat;
               nu = 1; ndv = 0;
            end
         end
         if (ns <= 2)      nd = int'(pid);
         else if (ns <= 4) nd = nr;
         else              nd = lo;
         m_state <= ns; m_out <= no; m_in <= ni; m_ramp <= nr; m_up <= nu;
         m_div <= ndv; m_sw <= nsw; m_dat <= nd;
         m_irst  <= (ns >= 3) ? 1 : 0;
         m_lock  <= (ns == 1 || ns == 2) ? 1 : 0;
         m_inwin <= (sig >= wmin && sig <= wmax) ? 1 : 0;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (run) begin
         chk("m_state", int'(st), m_state);
         chk("m_dat", int'(dat), m_dat);
         chk("m_int_rst", int'(irst), m_irst);
         chk("m_freeze", int'(frz), m_irst);
         chk("m_locked", int'(lck), m_lock);
      end
   end

   // Directed scenarios.
   initial begin
      int exp_ramp [4];
      bit seen;
      exp_ramp = '{80, 100, 70, 40};
      #1 rstn = 1'b0;
      cyc(2);
      run = 1'b1;
      chk("rst_dat", int'(dat), 0);
      chk("rst_state", int'(st), 0);
      chk("rst_int_rst", int'(irst), 0);
      chk("rst_locked", int'(lck), 0);
      rstn = 1'b1;

      // Lock acquisition and pass-through latency.
      cyc(1);
      enable = 1'b1;
      cyc(1);
      chk("lock_state", int'(st), 1);
      chk("lock_dat", int'(dat), 1234);
      chk("lock_locked", int'(lck), 1);
      pid = 14'sd50;
      cyc(1);
      chk("pass_latency", int'(dat), 50);

      // Short excursion: VERIFY then back to LOCKED.
      sig = 14'sd500;
      cyc(3);
      sig = 14'sd100;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (st == 3'd3 || irst) seen = 1'b1;
      end
      chk("short_no_sweep", int'(seen), 0);
      chk("short_relock", int'(st), 1);

      // Sustained loss: SWEEP four edges after the window flag falls.
      sig = 14'sd500;
      cyc(4);
      chk("verify_state", int'(st), 2);
      cyc(1);
      chk("sweep_state", int'(st), 3);
      chk("sweep_entry", int'(dat), 50);
      chk("sweep_int_rst", int'(irst), 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("ramp_seq", int'(dat), exp_ramp[i]);
      end

      // Two in-window cycles: SETTLE, frozen ramp, resume downward.
      sig = 14'sd100;
      cyc(1);
      chk("pre_settle_dat", int'(dat), 10);
      cyc(1);
      chk("settle_state", int'(st), 4);
      chk("settle_dat", int'(dat), -20);
      sig = 14'sd500;
      cyc(1);
      chk("settle_hold", int'(dat), -20);
      cyc(1);
      chk("resweep_state", int'(st), 3);
      chk("resweep_dat", int'(dat), -20);
      cyc(1);
      chk("resume_dir", int'(dat), -50);

      // Five in-window samples hand back to the PID.
      sig = 14'sd100;
      cyc(6);
      chk("handover_state", int'(st), 1);
      chk("handover_int_rst", int'(irst), 0);
      chk("handover_dat", int'(dat), 50);

      // Endless loss with a sweep limit of two.
      maxsw = 8'd2;
      sig = 14'sd500;
      seen = 1'b0;
      for (int i = 0; i < 120 && !seen; i++) begin
         cyc(1);
         if (st == 3'd5) seen = 1'b1;
      end
      if (TimeoutEn) begin
         chk("fail_reached", int'(seen), 1);
         chk("fail_dat", int'(dat), -100);
         chk("fail_int_rst", int'(irst), 1);
      end else begin
         chk("no_fail", int'(seen), 0);
      end
      enable = 1'b0;
      cyc(1);
      chk("disable_idle", int'(st), 0);

      // Inverted ramp limits pin the output.
      rmin = 14'sd50;
      rmax = -14'sd50;
      pid = 14'sd7;
      cyc(1);
      enable = 1'b1;
      cyc(1);
      chk("pin_state", int'(st), 3);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (dat != 14'sd50 || st == 3'd5) seen = 1'b1;
      end
      chk("pin_const", int'(seen), 0);

      // Asynchronous reset mid-sweep.
      #2 rstn = 1'b0;
      #1;
      chk("async_dat", int'(dat), 0);
      chk("async_state", int'(st), 0);
      chk("async_int_rst", int'(irst), 0);
      cyc(1);
      rstn = 1'b1;
      cyc(2);
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
